// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings, FSM state types and small burst helpers for the SRAM slave.
package axi4_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    function automatic logic [7:0] bytes_per_beat(input logic [2:0] size);
        return 8'd1 << size;
    endfunction

    function automatic logic [2:0] clamp_size(input logic [2:0] size, input logic [2:0] max_size);
        return (size > max_size) ? max_size : size;
    endfunction

    // Only power-of-two beat counts form a legal wrap window.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi4_burst_addr.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; encoding 2'b11 behaves as INCR.
module axi4_burst_addr
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] bpb;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    always_comb begin
        bpb       = ADDR_WIDTH'(bytes_per_beat(size));
        aligned   = addr & ~(bpb - ONE);
        incr      = aligned + bpb;
        // Window is (len+1) beats wide; the start address selects which window.
        wrap_mask = (ADDR_WIDTH'({1'b0, len} + 9'd1) << size) - ONE;
        case (burst)
            FIXED:   next_addr = addr;
            WRAP:    next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
            default: next_addr = incr;
        endcase
    end

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 slave backed by a byte-addressable on-chip SRAM; independent single-burst read and write paths.
// Define AXI4_SRAM_SLAVE_ERR_EN to report SLVERR for oversize SIZE, illegal WRAP length and out-of-range beats.
module axi4_sram_slave
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_BYTES  = 65536
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic [3:0]              awcache,
    input  logic [2:0]              awprot,
    input  logic [3:0]              awqos,
    input  logic [3:0]              awregion,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic [3:0]              arcache,
    input  logic [2:0]              arprot,
    input  logic [3:0]              arregion,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready,
    output wr_state_t               wr_state,
    output rd_state_t               rd_state
);

    // Every channel transfers on a cycle where valid and ready are both high at the rising edge;
    // a source never withdraws valid or changes payload while waiting for ready.

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int OFF_W    = $clog2(STRB_W);
    localparam int MEM_AW   = $clog2(MEM_BYTES);
    localparam int WORDS    = MEM_BYTES / STRB_W;
    localparam int IDX_W    = MEM_AW - OFF_W;
    localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic                  aw_hs, w_hs, ar_hs, r_hs;
    logic                  wr_beat_err, rd_beat_err;

    logic [ID_WIDTH-1:0]   wr_id;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_next;
    logic [7:0]            wr_len, wr_cnt;
    logic [2:0]            wr_size;
    logic [1:0]            wr_burst;
    logic                  wr_ovf, wr_err;

    logic [ADDR_WIDTH-1:0] rd_addr, rd_next, rd_cur;
    logic [7:0]            rd_len, rd_cnt, rd_cur_len;
    logic [2:0]            rd_size, rd_cur_size;
    logic [1:0]            rd_burst, rd_cur_burst;
    logic [IDX_W-1:0]      rd_idx, wr_idx;

    logic unused_sideband;
    assign unused_sideband = ^{awcache, awprot, awqos, awregion, arcache, arprot, arregion};

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;

    // While idle the read address path looks straight at AR so beat 0 is fetched on the handshake edge.
    always_comb begin
        if (rd_state == R_IDLE) begin
            rd_cur       = araddr;
            rd_cur_len   = arlen;
            rd_cur_size  = clamp_size(arsize, MAX_SIZE);
            rd_cur_burst = arburst;
        end else begin
            rd_cur       = rd_addr;
            rd_cur_len   = rd_len;
            rd_cur_size  = rd_size;
            rd_cur_burst = rd_burst;
        end
    end

    assign rd_idx = rd_cur[MEM_AW-1:OFF_W];
    assign wr_idx = wr_addr[MEM_AW-1:OFF_W];

    axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_addr (
        .addr      (wr_addr),
        .len       (wr_len),
        .size      (wr_size),
        .burst     (wr_burst),
        .next_addr (wr_next)
    );

    axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_addr (
        .addr      (rd_cur),
        .len       (rd_cur_len),
        .size      (rd_cur_size),
        .burst     (rd_cur_burst),
        .next_addr (rd_next)
    );

`ifdef AXI4_SRAM_SLAVE_ERR_EN
    logic wr_cfg_err, rd_cfg_err;

    function automatic logic cfg_err(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
        return (size > MAX_SIZE) || ((burst == WRAP) && !wrap_len_ok(len));
    endfunction

    function automatic logic oob(input logic [ADDR_WIDTH-1:0] a);
        return (a >> MEM_AW) != '0;
    endfunction

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_cfg_err <= 1'b0;
            rd_cfg_err <= 1'b0;
        end else begin
            if (aw_hs) wr_cfg_err <= cfg_err(awlen, awsize, awburst);
            if (ar_hs) rd_cfg_err <= cfg_err(arlen, arsize, arburst);
        end
    end

    assign wr_beat_err = wr_cfg_err || oob(wr_addr);
    assign rd_beat_err = ((rd_state == R_IDLE) ? cfg_err(arlen, arsize, arburst) : rd_cfg_err)
                         || oob(rd_cur);
`else
    assign wr_beat_err = 1'b0;
    assign rd_beat_err = 1'b0;
`endif

    // Byte-masked SRAM write port; erroring beats never reach the array.
    always_ff @(posedge aclk) begin
        if (w_hs && !wr_beat_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[wr_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state <= W_IDLE;
            awready  <= 1'b1;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bid      <= '0;
            bresp    <= '0;
            wr_id    <= '0;
            wr_addr  <= '0;
            wr_len   <= '0;
            wr_size  <= '0;
            wr_burst <= '0;
            wr_cnt   <= '0;
            wr_ovf   <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        wr_id    <= awid;
                        wr_addr  <= awaddr;
                        wr_len   <= awlen;
                        wr_size  <= clamp_size(awsize, MAX_SIZE);
                        wr_burst <= awburst;
                        wr_cnt   <= '0;
                        wr_ovf   <= 1'b0;
                        wr_err   <= 1'b0;
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        wr_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        wr_addr <= wr_next;
                        wr_cnt  <= wr_cnt + 8'd1;
                        // WLAST alone ends the burst; a short or long burst is flagged, not truncated.
                        if (wlast) begin
                            wready   <= 1'b0;
                            bvalid   <= 1'b1;
                            bid      <= wr_id;
                            bresp    <= (wr_err || wr_beat_err || wr_ovf || (wr_cnt != wr_len))
                                        ? SLVERR : OKAY;
                            wr_state <= W_RESP;
                        end else begin
                            if (wr_cnt == wr_len) wr_ovf <= 1'b1;
                            wr_err <= wr_err || wr_beat_err;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid   <= 1'b0;
                        awready  <= 1'b1;
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // rd_addr always holds the address of the next beat to fetch; rd_cnt counts beats fetched.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_state <= R_IDLE;
            arready  <= 1'b1;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rid      <= '0;
            rresp    <= '0;
            rdata    <= '0;
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_size  <= '0;
            rd_burst <= '0;
            rd_cnt   <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_len   <= arlen;
                        rd_size  <= clamp_size(arsize, MAX_SIZE);
                        rd_burst <= arburst;
                        rd_addr  <= rd_next;
                        rd_cnt   <= 8'd1;
                        rid      <= arid;
                        rdata    <= rd_beat_err ? '0 : mem[rd_idx];
                        rresp    <= rd_beat_err ? SLVERR : OKAY;
                        rlast    <= (arlen == 8'd0);
                        rvalid   <= 1'b1;
                        arready  <= 1'b0;
                        rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (rlast) begin
                            rvalid   <= 1'b0;
                            rlast    <= 1'b0;
                            arready  <= 1'b1;
                            rd_state <= R_IDLE;
                        end else begin
                            rd_addr <= rd_next;
                            rd_cnt  <= rd_cnt + 8'd1;
                            rdata   <= rd_beat_err ? '0 : mem[rd_idx];
                            rresp   <= rd_beat_err ? SLVERR : OKAY;
                            rlast   <= (rd_cnt == rd_len);
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave: bursts, strobes, backpressure, response stall, reset mid-read.
module tb_axi4_sram_slave;
    import axi4_pkg::*;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int MB = 65536;

    logic            aclk, areset;
    logic [IW-1:0]   awid, arid, bid, rid;
    logic [AW-1:0]   awaddr, araddr;
    logic [7:0]      awlen, arlen;
    logic [2:0]      awsize, arsize, awprot, arprot;
    logic [1:0]      awburst, arburst, bresp, rresp;
    logic [3:0]      awcache, awqos, awregion, arcache, arregion;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;
    wr_state_t       wr_st;
    rd_state_t       rd_st;

    logic [DW-1:0]   exp_q[$];
    int              vectors = 0;
    int              miscompares = 0;

    axi4_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_BYTES(MB)) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awcache(awcache), .awprot(awprot), .awqos(awqos), .awregion(awregion),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arcache(arcache), .arprot(arprot), .arregion(arregion),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .wr_state(wr_st), .rd_state(rd_st)
    );

    // Clock and reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expire(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: observed timeout expected handshake", tag);
    endtask

    // Driver tasks
    task automatic aw_send(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic hs;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 50 && !hs; i++) begin
            hs = awready;
            tick();
        end
        if (!hs) expire("aw_handshake");
        awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [DW-1:0] data, input logic [DW/8-1:0] strb, input logic last);
        logic hs;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 50 && !hs; i++) begin
            hs = wready;
            tick();
        end
        if (!hs) expire("w_handshake");
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic b_wait(input logic [IW-1:0] id, input logic [1:0] resp, input string tag);
        for (int i = 0; i < 50 && bvalid !== 1'b1; i++) tick();
        if (bvalid !== 1'b1) expire({tag, "_bvalid"});
        chk({tag, "_bid"}, DW'(bid), DW'(id));
        chk({tag, "_bresp"}, DW'(bresp), DW'(resp));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk({tag, "_awready_after_b"}, DW'(awready), DW'(1'b1));
    endtask

    task automatic ar_send(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic hs;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 50 && !hs; i++) begin
            hs = arready;
            tick();
        end
        if (!hs) expire("ar_handshake");
        arvalid = 1'b0;
    endtask

    // Scoreboard side: n beats of a total-beat burst, each compared with exp_q; RVALID must be
    // present every cycle (1-cycle first latency, no bubbles between beats).
    task automatic r_burst(input int n, input int total, input logic [IW-1:0] id,
                           input logic stall, input logic [1:0] resp, input string tag);
        logic [DW-1:0] exp;
        for (int i = 0; i < n; i++) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            if (stall) begin
                rready = 1'b0;
                chk({tag, "_rdata_pre_stall"}, rdata, exp);
                tick();
                chk({tag, "_rvalid_stall"}, DW'(rvalid), DW'(1'b1));
                chk({tag, "_rdata_stall"}, rdata, exp);
                chk({tag, "_arready_stall"}, DW'(arready), DW'(1'b0));
            end
            chk({tag, "_rvalid"}, DW'(rvalid), DW'(1'b1));
            chk({tag, "_rdata"}, rdata, exp);
            chk({tag, "_rlast"}, DW'(rlast), DW'(i == total - 1));
            chk({tag, "_rid"}, DW'(rid), DW'(id));
            chk({tag, "_rresp"}, DW'(rresp), DW'(resp));
            rready = 1'b1;
            tick();
            rready = 1'b0;
        end
        if (n == total) begin
            chk({tag, "_rvalid_end"}, DW'(rvalid), DW'(1'b0));
            chk({tag, "_arready_end"}, DW'(arready), DW'(1'b1));
        end
    endtask

    initial begin
        areset = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        awcache = '0; awprot = '0; awqos = '0; awregion = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arcache = '0; arprot = '0; arregion = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) tick();
        areset = 1'b0;
        tick();

        // Reset state
        chk("rst_awready", DW'(awready), DW'(1'b1));
        chk("rst_wready", DW'(wready), DW'(1'b0));
        chk("rst_bvalid", DW'(bvalid), DW'(1'b0));
        chk("rst_bid", DW'(bid), '0);
        chk("rst_bresp", DW'(bresp), '0);
        chk("rst_arready", DW'(arready), DW'(1'b1));
        chk("rst_rvalid", DW'(rvalid), DW'(1'b0));
        chk("rst_rlast", DW'(rlast), DW'(1'b0));
        chk("rst_rid", DW'(rid), '0);
        chk("rst_rresp", DW'(rresp), '0);
        chk("rst_rdata", rdata, '0);
        chk("rst_wr_state", DW'(wr_st), DW'(W_IDLE));
        chk("rst_rd_state", DW'(rd_st), DW'(R_IDLE));

        // INCR write 0x11..0x44 at 0x100
        aw_send(4'd3, 32'h100, 8'd3, 3'd3, INCR);
        chk("incr_wr_awready_busy", DW'(awready), DW'(1'b0));
        chk("incr_wr_wready", DW'(wready), DW'(1'b1));
        w_beat(64'h11, 8'hFF, 1'b0);
        w_beat(64'h22, 8'hFF, 1'b0);
        w_beat(64'h33, 8'hFF, 1'b0);
        w_beat(64'h44, 8'hFF, 1'b1);
        b_wait(4'd3, OKAY, "incr_wr");

        // INCR read back-to-back
        ar_send(4'd5, 32'h100, 8'd3, 3'd3, INCR);
        exp_q.push_back(64'h11); exp_q.push_back(64'h22);
        exp_q.push_back(64'h33); exp_q.push_back(64'h44);
        r_burst(4, 4, 4'd5, 1'b0, OKAY, "incr_rd");

        // WRAP read: 0x118, 0x100, 0x108, 0x110
        ar_send(4'd6, 32'h118, 8'd3, 3'd3, WRAP);
        exp_q.push_back(64'h44); exp_q.push_back(64'h11);
        exp_q.push_back(64'h22); exp_q.push_back(64'h33);
        r_burst(4, 4, 4'd6, 1'b0, OKAY, "wrap_rd");

        // Reserved burst encoding behaves as INCR
        ar_send(4'd7, 32'h108, 8'd1, 3'd3, 2'b11);
        exp_q.push_back(64'h22); exp_q.push_back(64'h33);
        r_burst(2, 2, 4'd7, 1'b0, OKAY, "rsvd_rd");

        // Strobed write over a zeroed word, then a narrow byte-lane-3 write
        aw_send(4'd1, 32'h200, 8'd0, 3'd3, INCR);
        w_beat(64'h0, 8'hFF, 1'b1);
        b_wait(4'd1, OKAY, "zero_wr");
        aw_send(4'd1, 32'h200, 8'd0, 3'd3, INCR);
        w_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b1);
        b_wait(4'd1, OKAY, "strb_wr");
        ar_send(4'd2, 32'h200, 8'd0, 3'd3, INCR);
        exp_q.push_back(64'h0000_0000_FFFF_FFFF);
        r_burst(1, 1, 4'd2, 1'b0, OKAY, "strb_rd");
        aw_send(4'd4, 32'h203, 8'd0, 3'd0, INCR);
        w_beat(64'hA5A5_A5A5_A5A5_A5A5, 8'h08, 1'b1);
        b_wait(4'd4, OKAY, "narrow_wr");
        ar_send(4'd2, 32'h200, 8'd0, 3'd3, INCR);
        exp_q.push_back(64'h0000_0000_A5FF_FFFF);
        r_burst(1, 1, 4'd2, 1'b0, OKAY, "narrow_rd");

        // FIXED write: every beat lands on 0x600, last one wins
        aw_send(4'd8, 32'h600, 8'd2, 3'd3, FIXED);
        w_beat(64'h1, 8'hFF, 1'b0);
        w_beat(64'h2, 8'hFF, 1'b0);
        w_beat(64'h3, 8'hFF, 1'b1);
        b_wait(4'd8, OKAY, "fixed_wr");
        ar_send(4'd8, 32'h600, 8'd0, 3'd3, INCR);
        exp_q.push_back(64'h3);
        r_burst(1, 1, 4'd8, 1'b0, OKAY, "fixed_rd");

        // LEN=7 read with RREADY toggling
        aw_send(4'd2, 32'h300, 8'd7, 3'd3, INCR);
        for (int i = 0; i < 8; i++) w_beat(64'hC0DE_0000_0000_0000 + 64'(i), 8'hFF, i == 7);
        b_wait(4'd2, OKAY, "bp_wr");
        ar_send(4'd11, 32'h300, 8'd7, 3'd3, INCR);
        for (int i = 0; i < 8; i++) exp_q.push_back(64'hC0DE_0000_0000_0000 + 64'(i));
        r_burst(8, 8, 4'd11, 1'b1, OKAY, "bp_rd");

        // BREADY held low while a LEN=0 read completes
        aw_send(4'd9, 32'h400, 8'd0, 3'd3, INCR);
        w_beat(64'h9999, 8'hFF, 1'b1);
        chk("bstall_bvalid_0", DW'(bvalid), DW'(1'b1));
        chk("bstall_bid_0", DW'(bid), DW'(4'd9));
        chk("bstall_awready_0", DW'(awready), DW'(1'b0));
        ar_send(4'd12, 32'h100, 8'd0, 3'd3, INCR);
        exp_q.push_back(64'h11);
        r_burst(1, 1, 4'd12, 1'b0, OKAY, "bstall_rd");
        for (int i = 0; i < 3; i++) begin
            chk("bstall_bvalid", DW'(bvalid), DW'(1'b1));
            chk("bstall_bid", DW'(bid), DW'(4'd9));
            chk("bstall_awready", DW'(awready), DW'(1'b0));
            tick();
        end
        b_wait(4'd9, OKAY, "bstall");

        // Early WLAST on beat 2 of a LEN=3 burst
        aw_send(4'd10, 32'h500, 8'd3, 3'd3, INCR);
        w_beat(64'h5, 8'hFF, 1'b0);
        w_beat(64'h6, 8'hFF, 1'b1);
        b_wait(4'd10, SLVERR, "early_wlast");

`ifdef AXI4_SRAM_SLAVE_ERR_EN
        ar_send(4'd13, 32'h0001_0000, 8'd0, 3'd3, INCR);
        exp_q.push_back(64'h0);
        r_burst(1, 1, 4'd13, 1'b0, SLVERR, "oob_rd");
`else
        // Without error checking the address aliases modulo the SRAM size
        ar_send(4'd13, 32'h0001_0100, 8'd0, 3'd3, INCR);
        exp_q.push_back(64'h11);
        r_burst(1, 1, 4'd13, 1'b0, OKAY, "alias_rd");
`endif

        // Reset asserted in the middle of a read burst
        ar_send(4'd14, 32'h300, 8'd7, 3'd3, INCR);
        exp_q.push_back(64'hC0DE_0000_0000_0000);
        exp_q.push_back(64'hC0DE_0000_0000_0001);
        r_burst(2, 8, 4'd14, 1'b0, OKAY, "midrst_rd");
        areset = 1'b1;
        #1;
        chk("midrst_rvalid", DW'(rvalid), DW'(1'b0));
        chk("midrst_arready", DW'(arready), DW'(1'b1));
        chk("midrst_rd_state", DW'(rd_st), DW'(R_IDLE));
        tick();
        areset = 1'b0;
        tick();

        // SRAM contents survive reset
        ar_send(4'd15, 32'h100, 8'd0, 3'd3, INCR);
        exp_q.push_back(64'h11);
        r_burst(1, 1, 4'd15, 1'b0, OKAY, "post_rst_rd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
